display_bcd_seq: RTL and testbench

- Sequential display stage downstream of the core's register-value output; replaces the purely combinational 8-digit decode.
- On a LOAD strobe it captures a 32-bit unsigned value and converts it to 8 BCD digits with shift-add-3 (double-dabble), one bit per clock.
- It then drives eight active-low 7-segment digits, UNIDADE through D_MILHAO.
- The displayed value holds steady until the next conversion completes.

---
 rtl/display_bcd_seq.sv | 157 +++++++++++++++
 tb/tb_display_bcd_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/display_bcd_seq.sv
// Sequential 8-digit BCD display: double-dabble converts a 32-bit value one bit per clock,
// then eight active-low 7-segment digits are decoded from the held result.
module display_bcd_seq_digit (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    if (dash) seg = 7'b0111111;
    else if (!blank) begin
      case (nib)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module display_bcd_seq #(
  parameter bit          BLANK_ZEROS = 1'b1,
  parameter logic [31:0] MAX_VAL     = 32'd99999999
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] DADO,
  input  logic        LOAD,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVERFLOW,
  output logic [6:0]  UNIDADE,
  output logic [6:0]  DEZENA,
  output logic [6:0]  CENTENA,
  output logic [6:0]  MILHAR,
  output logic [6:0]  D_MILHAR,
  output logic [6:0]  C_MILHAR,
  output logic [6:0]  MILHAO,
  output logic [6:0]  D_MILHAO
);
  localparam int NUM_DIGITS = 8;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [31:0] bcd_q, bcd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [31:0] disp_q, disp_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [31:0] adj, bcd_nxt;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
  end

  assign bcd_nxt = {adj[30:0], bin_q[31]};

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (LOAD) begin
        bin_d      = DADO;
        bcd_d      = '0;
        cnt_d      = '0;
        ovf_pend_d = (DADO > MAX_VAL);
        state_d    = CONV;
      end
      CONV: begin
        bcd_d = bcd_nxt;
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        // Last iteration: publish result straight from the adjusted/shifted value.
        if (cnt_q == 6'd31) begin
          disp_d  = bcd_nxt;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign BUSY     = (state_q == CONV);
  assign DONE     = done_q;
  assign OVERFLOW = ovf_q;

  // zero_above[i]: digit i and every digit above it are zero.
  logic [NUM_DIGITS:0]        zero_above;
  logic [NUM_DIGITS-1:0]      blank;
  logic [NUM_DIGITS-1:0][6:0] seg;

  assign zero_above[NUM_DIGITS] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign zero_above[g] = zero_above[g+1] & (disp_q[g*4 +: 4] == 4'd0);
    assign blank[g]      = BLANK_ZEROS && (g > 0) && zero_above[g];
    display_bcd_seq_digit u_dig (
      .nib   (disp_q[g*4 +: 4]),
      .blank (blank[g]),
      .dash  (ovf_q),
      .seg   (seg[g])
    );
  end

  assign UNIDADE  = seg[0];
  assign DEZENA   = seg[1];
  assign CENTENA  = seg[2];
  assign MILHAR   = seg[3];
  assign D_MILHAR = seg[4];
  assign C_MILHAR = seg[5];
  assign MILHAO   = seg[6];
  assign D_MILHAO = seg[7];
endmodule

// File: tb/tb_display_bcd_seq.sv
// Directed bench for display_bcd_seq: one instance with leading-zero blanking, one without.
module tb_display_bcd_seq;
  logic        clk = 1'b0;
  logic        rst, load;
  logic [31:0] dado;
  logic        busy_b, done_b, ovf_b, busy_n, done_n, ovf_n;
  logic [6:0]  b0, b1, b2, b3, b4, b5, b6, b7;
  logic [6:0]  n0, n1, n2, n3, n4, n5, n6, n7;
  logic [55:0] segs_b, segs_n;

  int n_vec = 0;
  int n_bad = 0;

  // Expected digit codes per nibble: 0-9 digit, A blank, B dash.
  logic [31:0] prev_b, prev_n;
  logic        prev_ovf;

  typedef struct {
    logic [31:0] dado;
    logic [31:0] exp_b;
    logic [31:0] exp_n;
    logic        ovf;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  display_bcd_seq #(.BLANK_ZEROS(1'b1)) u_b (
    .CLOCK(clk), .RESET(rst), .DADO(dado), .LOAD(load),
    .BUSY(busy_b), .DONE(done_b), .OVERFLOW(ovf_b),
    .UNIDADE(b0), .DEZENA(b1), .CENTENA(b2), .MILHAR(b3),
    .D_MILHAR(b4), .C_MILHAR(b5), .MILHAO(b6), .D_MILHAO(b7));

  display_bcd_seq #(.BLANK_ZEROS(1'b0)) u_n (
    .CLOCK(clk), .RESET(rst), .DADO(dado), .LOAD(load),
    .BUSY(busy_n), .DONE(done_n), .OVERFLOW(ovf_n),
    .UNIDADE(n0), .DEZENA(n1), .CENTENA(n2), .MILHAR(n3),
    .D_MILHAR(n4), .C_MILHAR(n5), .MILHAO(n6), .D_MILHAO(n7));

  assign segs_b = {b7, b6, b5, b4, b3, b2, b1, b0};
  assign segs_n = {n7, n6, n5, n4, n3, n2, n1, n0};

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b1111111;
      4'hB: return 7'b0111111;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  function automatic logic [55:0] expand(input logic [31:0] codes);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[i*7 +: 7] = seg_of(codes[i*4 +: 4]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_disp(input string name, input logic [31:0] eb, input logic [31:0] en,
                          input logic eo);
    chk({name, "_segs_blank"}, {8'h0, segs_b}, {8'h0, expand(eb)});
    chk({name, "_segs_noblank"}, {8'h0, segs_n}, {8'h0, expand(en)});
    chk({name, "_ovf"}, {63'h0, ovf_b}, {63'h0, eo});
  endtask

  // Called just after the accepting edge (cycle count = start); returns edges until DONE seen.
  task automatic wait_done(input int start, output int lat);
    int busy_err = 0;
    lat = -1;
    for (int n = start + 1; n <= start + 45; n++) begin
      step();
      if (n == 31)
        chk("hold_before_done", {8'h0, segs_b}, {8'h0, expand(prev_b)});
      if (done_b) begin
        lat = n;
        break;
      end
      if (busy_b !== 1'b1) busy_err++;
    end
    chk("busy_span", 64'(busy_err), 64'd0);
  endtask

  task automatic load_val(input logic [31:0] d);
    dado = d;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    load_val(v.dado);
    chk("busy_after_load", {63'h0, busy_b}, 64'd1);
    wait_done(0, lat);
    chk("latency", 64'(lat), 64'd32);
    chk("busy_at_done", {63'h0, busy_b}, 64'd0);
    chk_disp("result", v.exp_b, v.exp_n, v.ovf);
    prev_b = v.exp_b; prev_n = v.exp_n; prev_ovf = v.ovf;
    step();
    chk("done_one_cycle", {63'h0, done_b}, 64'd0);
  endtask

  initial begin
    int lat, done_seen;
    tbl[0] = '{32'd12345678,   32'h12345678, 32'h12345678, 1'b0};
    tbl[1] = '{32'd1005,       32'hAAAA1005, 32'h00001005, 1'b0};
    tbl[2] = '{32'd0,          32'hAAAAAAA0, 32'h00000000, 1'b0};
    tbl[3] = '{32'd99999999,   32'h99999999, 32'h99999999, 1'b0};
    tbl[4] = '{32'd100000000,  32'hBBBBBBBB, 32'hBBBBBBBB, 1'b1};
    tbl[5] = '{32'hFFFFFFFF,   32'hBBBBBBBB, 32'hBBBBBBBB, 1'b1};
    tbl[6] = '{32'd9009,       32'hAAAA9009, 32'h00009009, 1'b0};

    rst = 1'b1; load = 1'b0; dado = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_busy", {63'h0, busy_b}, 64'd0);
    chk("reset_done", {63'h0, done_b}, 64'd0);
    chk_disp("reset", 32'hAAAAAAA0, 32'h00000000, 1'b0);
    prev_b = 32'hAAAAAAA0; prev_n = 32'h0; prev_ovf = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // LOAD during a conversion is dropped; LOAD in the DONE cycle is taken.
    load_val(32'd42);
    for (int i = 0; i < 9; i++) step();
    dado = 32'd7; load = 1'b1;
    step();
    load = 1'b0;
    wait_done(10, lat);
    chk("busy_load_latency", 64'(lat), 64'd32);
    chk_disp("busy_load_ignored", 32'hAAAAAA42, 32'h00000042, 1'b0);
    prev_b = 32'hAAAAAA42; prev_n = 32'h42; prev_ovf = 1'b0;
    dado = 32'd7; load = 1'b1;
    step();
    load = 1'b0;
    chk("done_cycle_load_busy", {63'h0, busy_b}, 64'd1);
    wait_done(0, lat);
    chk("done_cycle_load_latency", 64'(lat), 64'd32);
    chk_disp("done_cycle_load", 32'hAAAAAAA7, 32'h00000007, 1'b0);
    prev_b = 32'hAAAAAAA7; prev_n = 32'h7; prev_ovf = 1'b0;
    step();

    // Reset mid-conversion aborts and restores the reset display.
    load_val(32'd555);
    for (int i = 0; i < 14; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {63'h0, busy_b}, 64'd0);
    chk("abort_done", {63'h0, done_b}, 64'd0);
    chk_disp("abort", 32'hAAAAAAA0, 32'h00000000, 1'b0);
    prev_b = 32'hAAAAAAA0; prev_n = 32'h0; prev_ovf = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done_b) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    run_vec('{32'd555, 32'hAAAAA555, 32'h00000555, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
